// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: four-phase-handshake UART transmitter, LSB first, optional parity, 1 or 2 stop bits
module uart_tx_serializer #(
   parameter int DATA_BITS    = 8,
   parameter int BAUD_DIVISOR = 326,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_tx_start,
   input  logic [DATA_BITS-1:0] i_tx_data,
   output logic                 o_tx,
   output logic                 o_tx_done,
   output logic                 o_busy
);
   localparam int BW = $clog2(BAUD_DIVISOR);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIVISOR - 1);
   localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic ODD = 1'(PARITY == 1);
   generate
      if (PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || DATA_BITS < 5 || DATA_BITS > 8 || BAUD_DIVISOR < 2) begin : g_bad
         $error("uart_tx_serializer: unsupported parameter combination");
      end
   endgenerate
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_ACK} state_t;
   state_t state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0] bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic par_q, par_d, tx_q, tx_d, done_q, done_d, busy_q, busy_d, tick;
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      done_d  = done_q;
      busy_d  = busy_q;
      tick    = baud_q == BAUD_LAST;
      if (state_q != S_IDLE && state_q != S_ACK) baud_d = tick ? '0 : baud_q + 1'b1;
      unique case (state_q)
         S_IDLE: if (i_tx_start) begin
            shift_d = i_tx_data;
            par_d   = ^i_tx_data ^ ODD;
            baud_d  = '0;
            bit_d   = '0;
            busy_d  = 1'b1;
            state_d = S_START;
         end
         S_START: if (tick) begin
            bit_d   = '0;
            state_d = S_DATA;
         end
         S_DATA: if (tick) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q == DATA_LAST ? 3'd0 : bit_q + 3'd1;
            state_d = bit_q != DATA_LAST ? S_DATA : PARITY != 0 ? S_PAR : S_STOP;
         end
         S_PAR: if (tick) begin
            bit_d   = '0;
            state_d = S_STOP;
         end
         S_STOP: if (tick) begin
            bit_d   = bit_q + 3'd1;
            done_d  = bit_q == STOP_LAST;
            state_d = bit_q == STOP_LAST ? S_ACK : S_STOP;
         end
         S_ACK: if (!i_tx_start) begin
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // line level is registered from the next state so it changes on the same edge as the state
      tx_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] : state_d == S_PAR ? par_d : 1'b1;
   end
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end
   assign o_tx      = tx_q;
   assign o_tx_done = done_q;
   assign o_busy    = busy_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: four configurations (8N1, 8O1, 8E1, 8N2) at 4 clocks per bit, checked cycle by cycle
module tb_uart_tx_serializer;
   localparam int DIV = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] start = '0;
   logic [3:0][7:0] data = '0;
   logic [3:0] tx, done, busy;
   int tests = 0, fails = 0, acks = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 4; g++) begin : g_lane
      uart_tx_serializer #(
         .DATA_BITS(8), .BAUD_DIVISOR(DIV),
         .PARITY(g == 1 ? 1 : g == 2 ? 2 : 0), .STOP_BITS(g == 3 ? 2 : 1)
      ) u_dut (
         .i_clk(clk), .i_reset(rst_n), .i_tx_start(start[g]), .i_tx_data(data[g]),
         .o_tx(tx[g]), .o_tx_done(done[g]), .o_busy(busy[g])
      );
   end
   typedef struct {int ln; logic [7:0] d; logic [11:0] line; int n; int hold;} vec_t;
   typedef bit bitq_t[$];
   // reference frame: start, data LSB first, parity by popcount, stop bits
   function automatic bitq_t model(input int ln, input logic [7:0] d);
      bitq_t q;
      int par = ln == 1 ? 1 : ln == 2 ? 2 : 0;
      int stb = ln == 3 ? 2 : 1;
      bit ones_odd = ($countones(d) % 2) == 1;
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(d[i]);
      if (par == 2) q.push_back(ones_odd);
      if (par == 1) q.push_back(!ones_odd);
      repeat (stb) q.push_back(1'b1);
      return q;
   endfunction
   function automatic logic [11:0] to_line(input bitq_t q);
      logic [11:0] r = '1;
      foreach (q[k]) r[k] = q[k];
      return r;
   endfunction
   task automatic chk(input string nm, input int ln, input logic a, input logic e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s lane%0d t=%0t got %b expected %b", nm, ln, $time, a, e);
      end
   endtask
   task automatic run(input int ln, input logic [7:0] d, input logic [11:0] line, input int n,
                      input int drop_at, input int chg_at, input int hold);
      start[ln] = 1'b1;
      data[ln] = d;
      @(posedge clk); #1;
      for (int i = 0; i < n * DIV; i++) begin
         if (i == drop_at) start[ln] = 1'b0;
         if (i == chg_at) data[ln] = ~d;
         chk("tx_bit", ln, tx[ln], line[i / DIV]);
         chk("done_early", ln, done[ln], 1'b0);
         chk("busy_frame", ln, busy[ln], 1'b1);
         @(posedge clk); #1;
      end
      chk("done_rise", ln, done[ln], 1'b1);
      chk("ack_tx", ln, tx[ln], 1'b1);
      chk("ack_busy", ln, busy[ln], 1'b1);
      if (done[ln]) acks++;
      if (start[ln]) begin
         repeat (hold) begin
            @(posedge clk); #1;
            chk("done_hold", ln, done[ln], 1'b1);
            chk("busy_hold", ln, busy[ln], 1'b1);
         end
         start[ln] = 1'b0;
      end
      @(posedge clk); #1;
      chk("done_clr", ln, done[ln], 1'b0);
      chk("busy_clr", ln, busy[ln], 1'b0);
      chk("idle_tx", ln, tx[ln], 1'b1);
   endtask
   task automatic idle_chk(input int ln, input int cycles);
      repeat (cycles) begin
         @(posedge clk); #1;
         chk("no_retrig_tx", ln, tx[ln], 1'b1);
         chk("no_retrig_busy", ln, busy[ln], 1'b0);
      end
   endtask
   initial begin
      vec_t vecs[6];
      bitq_t q;
      logic [7:0] burst[4];
      logic [7:0] d;
      int ln, n, drop;
      vecs[0] = '{0, 8'h1B, 12'b001000110110, 10, 10};
      vecs[1] = '{0, 8'hA5, 12'b001101001010, 10, 0};
      vecs[2] = '{1, 8'h1B, 12'b011000110110, 11, 2};
      vecs[3] = '{2, 8'h1B, 12'b010000110110, 11, 1};
      vecs[4] = '{3, 8'h1B, 12'b011000110110, 11, 0};
      vecs[5] = '{3, 8'hA5, 12'b111101001010, 11, 3};
      burst = '{8'h1B, 8'hA5, 8'hE9, 8'h3F};
      start = '1;
      data = {8'h55, 8'h00, 8'hFF, 8'h1B};
      repeat (3) begin
         @(posedge clk); #1;
         for (int l = 0; l < 4; l++) begin
            chk("rst_tx", l, tx[l], 1'b1);
            chk("rst_done", l, done[l], 1'b0);
            chk("rst_busy", l, busy[l], 1'b0);
         end
      end
      start = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         run(vecs[i].ln, vecs[i].d, vecs[i].line, vecs[i].n, -1, i == 1 ? 17 : -1, vecs[i].hold);
         if (i == 0) idle_chk(0, 3);
      end
      start[0] = 1'b1;
      data[0] = 8'hFF;
      @(posedge clk); #1;
      repeat (4 * DIV + 1) begin
         @(posedge clk); #1;
      end
      chk("mid_busy", 0, busy[0], 1'b1);
      chk("mid_tx", 0, tx[0], 1'b1);
      rst_n = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("mid_rst_tx", 0, tx[0], 1'b1);
         chk("mid_rst_busy", 0, busy[0], 1'b0);
         chk("mid_rst_done", 0, done[0], 1'b0);
      end
      rst_n = 1'b1;
      q = model(0, 8'hFF);
      run(0, 8'hFF, to_line(q), q.size(), -1, -1, 0);
      acks = 0;
      foreach (burst[b]) begin
         q = model(0, burst[b]);
         run(0, burst[b], to_line(q), q.size(), -1, -1, 0);
      end
      tests++;
      if (acks != 4) begin
         fails++;
         $display("FAIL burst_acks got %0d expected 4", acks);
      end
      repeat (24) begin
         ln = $urandom_range(0, 3);
         d = 8'($urandom);
         q = model(ln, d);
         n = q.size();
         drop = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, n * DIV - 1)) : -1;
         run(ln, d, to_line(q), n, drop, $urandom_range(0, n * DIV - 1), $urandom_range(0, 3));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
